// File: rtl/latency_credit_ctrl_pkg.sv
// Shared constants for the latency/credit controller slice.
package latency_credit_ctrl_pkg;

    // Bits needed to hold values 0..n-1; never narrower than 1 bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/latency_credit_ctrl_sync_fifo.sv
// Show-ahead synchronous FIFO with non-power-of-two depth and occupancy count.
module sync_fifo
    import latency_credit_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        rd_en,
    output logic [WIDTH-1:0]            rd_data,
    output logic [clog2(DEPTH+1)-1:0]   count,
    output logic                        full
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign do_wr   = wr_en & ~full & ~clr;
    assign do_rd   = rd_en & (count != '0) & ~clr;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    // Storage carries no reset; contents are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/latency_credit_ctrl.sv
// Credit-based launch control for a fixed-latency datapath feeding a show-ahead output buffer.
module latency_credit_ctrl
    import latency_credit_ctrl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 3,
    parameter int DEPTH   = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        flush,
    output logic                        dp_en,
    input  logic [WIDTH-1:0]            dp_dout,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [WIDTH-1:0]            m_data,
    output logic [clog2(DEPTH+1)-1:0]   used,
    output logic                        ovf
);

    localparam int CW = clog2(DEPTH+1);

    // vld_pipe[k] is high when a launch happened k cycles ago.
    logic [LATENCY:1] vld_pipe;
    logic             wr, pop, full;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    next_used;

    assign dp_en   = s_valid & s_ready & ~flush;
    assign m_valid = (fifo_count != '0);
    assign pop     = m_valid & m_ready & ~flush;
    assign wr      = vld_pipe[LATENCY] & ~flush;

    always_comb begin
        next_used = used;
        if (flush) next_used = '0;
        else       next_used = used + CW'(dp_en) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            used     <= '0;
            s_ready  <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            used    <= next_used;
            s_ready <= (next_used < CW'(DEPTH)) & ~flush;
            if (wr && full) ovf <= 1'b1;
            if (flush) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe[1] <= dp_en;
                for (int k = 2; k <= LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
            end
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .wr_en   (wr),
        .wr_data (dp_dout),
        .rd_en   (pop),
        .rd_data (m_data),
        .count   (fifo_count),
        .full    (full)
    );

endmodule

// File: tb/tb_latency_credit_ctrl.sv
// Directed bench: 3-cycle datapath model emitting a per-launch counter.
module tb_latency_credit_ctrl;

    logic       clk, rst_n;
    logic       s_valid, s_ready, flush, dp_en;
    logic [7:0] dp_dout, m_data;
    logic       m_valid, m_ready, ovf;
    logic [2:0] used;

    int errors = 0, checks = 0;
    int launches = 0, pops = 0, exp_data = 1, cyc = 0;
    int first_launch = -1, first_mv = -1, bubbles = 0, max_used = 0;

    latency_credit_ctrl #(.WIDTH(8), .LATENCY(3), .DEPTH(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .flush   (flush),
        .dp_en   (dp_en),
        .dp_dout (dp_dout),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .used    (used),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: result = launch sequence number, valid 3 cycles after launch.
    logic [7:0] cnt, d1, d2, d3;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            d1  <= 8'hEE;
            d2  <= 8'hEE;
            d3  <= 8'hEE;
        end else begin
            if (dp_en) cnt <= cnt + 8'd1;
            d1 <= dp_en ? cnt + 8'd1 : 8'hEE;
            d2 <= d1;
            d3 <= d2;
        end
    end
    assign dp_dout = d3;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive one set of inputs per cycle, observe launch/pop before the edge.
    task automatic run(input string tag, input int n, input logic sv, input logic mr);
        for (int i = 0; i < n; i++) begin
            s_valid = sv;
            m_ready = mr;
            #1;
            if (dp_en) begin
                launches++;
                if (first_launch < 0) first_launch = cyc;
            end
            if (m_valid) begin
                if (first_mv < 0) first_mv = cyc;
            end else if (first_mv >= 0 && mr) begin
                bubbles++;
            end
            if (int'(used) > max_used) max_used = int'(used);
            if (m_valid && m_ready) begin
                chk(tag, m_data, exp_data);
                exp_data++;
                pops++;
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic rst_pulse();
        s_valid = 1'b0;
        m_ready = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_used", used, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        #1 chk("rel_s_ready_pre", s_ready, 0);
        @(negedge clk);
        chk("rel_s_ready", s_ready, 1);

        // Streaming
        run("st_data", 20, 1'b1, 1'b1);
        chk("st_launches", launches, 20);
        chk("st_first_lat", first_mv - first_launch, 4);
        chk("st_bubbles", bubbles, 0);
        chk("st_used_le4", max_used <= 4, 1);
        run("st_drain", 6, 1'b0, 1'b1);
        chk("st_pops", pops, 20);
        chk("st_used_end", used, 0);

        // Backpressure and credit return
        rst_pulse();
        launches = 0; pops = 0; exp_data = 1;
        run("bp_data", 12, 1'b1, 1'b0);
        chk("bp_launches", launches, 5);
        chk("bp_s_ready", s_ready, 0);
        chk("bp_used", used, 5);
        chk("bp_head", m_data, 1);
        run("cr_pop", 1, 1'b1, 1'b1);
        chk("cr_s_ready", s_ready, 1);
        chk("cr_used_dip", used, 4);
        run("cr_launch", 1, 1'b1, 1'b0);
        chk("cr_launches", launches, 6);
        chk("cr_used_back", used, 5);
        chk("cr_s_ready_off", s_ready, 0);
        run("cr_hold", 3, 1'b1, 1'b0);
        chk("cr_no_extra", launches, 6);
        run("bp_drain", 10, 1'b0, 1'b1);
        chk("bp_pops", pops, 6);
        chk("bp_used_end", used, 0);
        chk("bp_ovf", ovf, 0);

        // Flush with 2 buffered (7,8) and 2 in flight (9,10)
        launches = 0; pops = 0;
        run("fl_fill", 4, 1'b1, 1'b0);
        run("fl_gap", 1, 1'b0, 1'b0);
        chk("fl_used_pre", used, 4);
        chk("fl_mvalid_pre", m_valid, 1);
        flush = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
        #1 chk("fl_dp_en_masked", dp_en, 0);
        @(negedge clk);
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        chk("fl_m_valid", m_valid, 0);
        chk("fl_used", used, 0);
        chk("fl_s_ready", s_ready, 0);
        run("fl_stale", 8, 1'b0, 1'b1);
        chk("fl_no_stale", pops, 0);
        exp_data = 11;
        run("fl_new", 2, 1'b1, 1'b1);
        run("fl_new_drain", 6, 1'b0, 1'b1);
        chk("fl_new_pops", pops, 2);
        chk("fl_ovf", ovf, 0);

        // Reset during streaming
        run("mr_pre", 8, 1'b1, 1'b1);
        chk("mr_pre_mvalid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_s_ready", s_ready, 0);
        chk("mr_m_valid", m_valid, 0);
        chk("mr_used", used, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_data = 1; pops = 0;
        run("mr_post", 12, 1'b1, 1'b1);
        chk("mr_post_pops", pops, 7);
        chk("mr_ovf", ovf, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/latency_credit_ctrl.md
LATENCY_CREDIT_CTRL -- requirements
Module: latency_credit_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: datapath output data width in bits.
REQ-002 SHALL have parameter LATENCY, default 3: fixed datapath latency in cycles, legal range 1 or more.
REQ-003 SHALL have parameter DEPTH, default 5: output buffer entries and total credits; legal when DEPTH >= LATENCY+2.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port s_valid, input, 1 bit: upstream sample present.
REQ-007 SHALL have port s_ready, output, 1 bit: registered; controller accepts a sample.
REQ-008 SHALL have port flush, input, 1 bit: synchronous discard of all in-flight and buffered data.
REQ-009 SHALL have port dp_en, output, 1 bit: launch strobe to the datapath.
REQ-010 SHALL have port dp_dout, input, WIDTH bits: datapath result.
REQ-011 SHALL have port m_valid, output, 1 bit: buffered result available.
REQ-012 SHALL have port m_ready, input, 1 bit: downstream accepts a result.
REQ-013 SHALL have port m_data, output, WIDTH bits: head of the output buffer.
REQ-014 SHALL have port used, output, clog2(DEPTH+1) bits: in-flight count plus buffered count.
REQ-015 SHALL have port ovf, output, 1 bit: sticky buffer-overflow error.

Function
REQ-016 SHALL drive dp_en = s_valid & s_ready & !flush combinationally; a launch is a cycle with dp_en high.
REQ-017 SHALL treat dp_dout as valid exactly in cycle t+LATENCY for a launch in cycle t; dp_dout in all other cycles is ignored.
REQ-018 SHALL track launches with a LATENCY-stage valid shift register; when its last stage is high, it SHALL write dp_dout into the buffer on that edge.
REQ-019 SHALL use a show-ahead buffer: m_valid = buffer not empty, m_data = oldest entry; a pop is m_valid & m_ready.
REQ-020 SHALL update used by +1 per launch and -1 per pop; a simultaneous launch and pop SHALL leave used unchanged.
REQ-021 SHALL register s_ready as (next used < DEPTH) & !flush, so a credit freed by a pop is reusable from the following cycle.
REQ-022 SHALL give first-result latency of LATENCY+1 cycles from launch to m_valid, and sustain 1 result per cycle when m_ready stays high.
REQ-023 SHALL preserve launch order at the output, with no loss or duplication.
REQ-024 SHALL clear, on an edge with flush high, the shift register, the buffer, used and s_ready; it SHALL ignore launch, write and pop in that cycle; results of earlier launches SHALL never be written; ovf SHALL be unaffected.
REQ-025 SHALL set ovf on a write into a full buffer, drop that write, and hold ovf until reset; ovf is unreachable with legal parameters.
REQ-026 SHALL hold used <= DEPTH at all times.

Reset
REQ-027 SHALL, while rst_n is low, hold s_ready=0, m_valid=0, used=0, ovf=0 and all shift register stages at 0; m_data is don't-care.
REQ-028 SHALL raise s_ready on the first edge after rst_n release; reset asserted mid-operation SHALL discard all data immediately.

Structure
REQ-029 SHALL place the clog2 width function in the team's shared constants package; the block needs no typedefs.
REQ-030 SHALL instantiate the buffer as sub-module sync_fifo (WIDTH, DEPTH, show-ahead, count and full outputs); credit and valid tracking stay in the top level.

Verification (WIDTH=8, LATENCY=3, DEPTH=5; datapath model = 3-cycle delay of a counter incremented per launch)
REQ-031 SHALL check reset: with rst_n low, s_ready=0, m_valid=0, used=0 and ovf=0; s_ready=1 one cycle after release.
REQ-032 SHALL check streaming: s_valid=1 and m_ready=1 continuous -> m_valid rises 4 cycles after the first launch, m_data=1,2,3,... with no bubbles, and used stays at 4 or below.
REQ-033 SHALL check backpressure: m_ready=0 and s_valid=1 -> exactly 5 launches, then s_ready=0 and used=5; then m_ready=1 -> outputs 1..5 in order, ovf=0.
REQ-034 SHALL check credit return: with used=5, one pop -> s_ready=1 next cycle, exactly one launch accepted, used returns to 5.
REQ-035 SHALL check flush: with 2 launches in flight and 2 entries buffered, flush for 1 cycle -> m_valid=0 and used=0 next cycle, and the 2 in-flight results never appear.
REQ-036 SHALL check mid-operation reset: reset pulsed during streaming -> outputs return to reset values immediately, and after release the stream restarts with no stale data.
